// File: rtl/shift_unit_pipe.sv
// Pipelined funnel shifter functional unit for the Tomasulo back end.
// Results are broadcast on the CDB tagged with TAG; an un-granted result is held in place.
package shift_unit_pkg;
  localparam int DWIDTH = 32;

  typedef enum logic [3:0] {
    NO_VAL  = 4'd0,
    SHIFT_1 = 4'd1,
    SHIFT_2 = 4'd2
  } rs_tag_t;

  typedef enum logic [3:0] {
    SLLR, SLLI, SRLR, SRLI, SRAR, SRAI, SRR, SRRI, SLR, SLRI
  } shift_op_t;

  typedef struct packed {
    rs_tag_t             tag;
    logic [DWIDTH-1:0]   val;
  } cdb_t;
endpackage

module shift_unit_pipe
  import shift_unit_pkg::*;
#(
  parameter rs_tag_t TAG       = SHIFT_1,
  parameter int      DATA_W    = DWIDTH,
  parameter int      STAGES    = 2,
  parameter bit      ROTATE_EN = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  shift_op_t         oper_i,
  input  logic [DATA_W-1:0] rs1_val_i,
  input  logic [DATA_W-1:0] rs2_val_i,
  input  logic              flush_i,
  input  logic              cdb_grant_i,
  output logic              busy_o,
  output cdb_t              cdb_term_o
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int FW   = 2 * DATA_W - 1;

  // Applies the funnel levels owned by stage grp; levels run from the largest shift down.
  function automatic logic [FW-1:0] funnel_levels(input logic [FW-1:0] z,
                                                  input logic [SH_W-1:0] sh,
                                                  input logic left,
                                                  input int grp);
    logic [FW-1:0] acc;
    acc = z;
    for (int lvl = 0; lvl < SH_W; lvl++) begin
      if (((lvl * STAGES) / SH_W == grp) && (sh[SH_W-1-lvl] ^ left))
        acc = acc >> (1 << (SH_W - 1 - lvl));
    end
    return acc;
  endfunction

  logic              w_advance;
  logic              w_legal;
  logic              w_left;
  logic [DATA_W-2:0] w_hi;
  logic              w_mid;
  logic [DATA_W-2:0] w_lo;
  logic [FW-1:0]     w_z_in;
  logic [SH_W-1:0]   w_shamt;
  logic              w_unused_rs2;
  logic              w_unused_z;

  logic [FW-1:0]     r_z_p    [STAGES];
  logic [SH_W-1:0]   r_sh_p   [STAGES];
  logic [STAGES-1:0] r_left_p;
  logic [STAGES-1:0] r_vld_p;
  logic [FW-1:0]     w_z_next [STAGES];
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_val;

  assign w_advance    = ~r_out_vld | cdb_grant_i;
  assign ready_o      = w_advance;
  assign busy_o       = (|r_vld_p) | r_out_vld;
  assign w_shamt      = rs2_val_i[SH_W-1:0];
  assign w_unused_rs2 = ^rs2_val_i[DATA_W-1:SH_W];

  // Left shifts and left rotates become right shifts by the inverted amount.
  always_comb begin
    w_legal = 1'b1;
    w_left  = 1'b0;
    w_hi    = '0;
    w_mid   = rs1_val_i[DATA_W-1];
    w_lo    = rs1_val_i[DATA_W-2:0];
    case (oper_i)
      SLLR, SLLI: begin
        w_hi   = rs1_val_i[DATA_W-1:1];
        w_mid  = rs1_val_i[0];
        w_lo   = '0;
        w_left = 1'b1;
      end
      SRLR, SRLI: ;
      SRAR, SRAI: w_hi = {(DATA_W-1){rs1_val_i[DATA_W-1]}};
      SRR, SRRI: begin
        w_hi    = rs1_val_i[DATA_W-2:0];
        w_legal = ROTATE_EN;
      end
      SLR, SLRI: begin
        w_hi    = rs1_val_i[DATA_W-1:1];
        w_mid   = rs1_val_i[0];
        w_lo    = rs1_val_i[DATA_W-1:1];
        w_left  = 1'b1;
        w_legal = ROTATE_EN;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_z_in = {w_hi, w_mid, w_lo};

  for (genvar g = 0; g < STAGES; g++) begin : g_lvl
    assign w_z_next[g] = funnel_levels(r_z_p[g], r_sh_p[g], r_left_p[g], g);
  end

  assign w_unused_z = ^w_z_next[STAGES-1][FW-1:DATA_W];

  // Stage valids and output valid; illegal ops enter as bubbles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_p   <= '0;
      r_out_vld <= 1'b0;
    end else if (flush_i) begin
      r_vld_p   <= '0;
      r_out_vld <= 1'b0;
    end else if (w_advance) begin
      r_vld_p[0] <= valid_i & w_legal;
      for (int i = 1; i < STAGES; i++) r_vld_p[i] <= r_vld_p[i-1];
      r_out_vld <= r_vld_p[STAGES-1];
    end
  end

  // p0 captures the funnel; each later boundary applies its group of levels.
  always_ff @(posedge clk_i) begin
    if (w_advance) begin
      r_z_p[0]    <= w_z_in;
      r_sh_p[0]   <= w_shamt;
      r_left_p[0] <= w_left;
      for (int i = 1; i < STAGES; i++) begin
        r_z_p[i]    <= w_z_next[i-1];
        r_sh_p[i]   <= r_sh_p[i-1];
        r_left_p[i] <= r_left_p[i-1];
      end
      r_out_val <= w_z_next[STAGES-1][DATA_W-1:0];
    end
  end

  always_comb begin
    cdb_term_o.tag = NO_VAL;
    cdb_term_o.val = '0;
    if (r_out_vld) begin
      cdb_term_o.tag = TAG;
      cdb_term_o.val = DWIDTH'(r_out_val);
    end
  end

endmodule
